// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage owning the PC and the IF/ID pipeline register.
// Latency: word at imem_ra appears on ifid_inst one cycle later; imem_ra is combinational from pc.
// Backpressure: stall holds pc and IF/ID exactly; redirect overrides stall and flushes IF/ID.
//
// Ports:
//   clk, rst_n                 rising-edge clock, synchronous active-low reset
//   stall                      hold request from decode/hazard logic
//   redirect_valid/_target     taken branch/jump and its byte-address target
//   imem_ra / imem_rd          combinational instruction memory read address / data
//   ifid_valid/_pc/_pc_plus4/_inst  IF/ID register contents for decode
//   fetch_misalign             misaligned-redirect flag, present only with FETCH_MISALIGN_CHK_EN
//
// Optional feature macro: FETCH_MISALIGN_CHK_EN. When undefined, redirect targets are
// silently word-aligned; when defined, a misaligned target is dropped and flagged.
module fetch_unit #(
  parameter int                     INS_ADDRESS = 9,
  parameter int                     INS_W       = 32,
  parameter logic [INS_ADDRESS-1:0] RESET_PC    = '0,
  parameter logic [INS_W-1:0]       NOP_INST    = 32'h00000013
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   stall,
  input  logic                   redirect_valid,
  input  logic [INS_ADDRESS-1:0] redirect_target,
  output logic [INS_ADDRESS-1:0] imem_ra,
  input  logic [INS_W-1:0]       imem_rd,
  output logic                   ifid_valid,
  output logic [INS_ADDRESS-1:0] ifid_pc,
  output logic [INS_ADDRESS-1:0] ifid_pc_plus4,
`ifdef FETCH_MISALIGN_CHK_EN
  output logic                   fetch_misalign,
`endif
  output logic [INS_W-1:0]       ifid_inst
);

  // Clears the two byte-offset bits so the PC can never hold a misaligned address.
  localparam logic [INS_ADDRESS-1:0] ALIGN_MASK = {{(INS_ADDRESS-2){1'b1}}, 2'b00};
  localparam logic [INS_ADDRESS-1:0] FOUR       = INS_ADDRESS'(4);

  logic [INS_ADDRESS-1:0] pc_q, pc_d;
  logic                   valid_q, valid_d;
  logic [INS_ADDRESS-1:0] ifid_pc_q, ifid_pc_d;
  logic [INS_ADDRESS-1:0] ifid_pc4_q, ifid_pc4_d;
  logic [INS_W-1:0]       inst_q, inst_d;
  logic                   mis_q, mis_d;
  logic [INS_ADDRESS-1:0] pc_plus4;

  // Carry out of the add is discarded, so the PC wraps at 2**INS_ADDRESS.
  assign pc_plus4 = pc_q + FOUR;

  always_comb begin
    pc_d       = pc_q;
    valid_d    = valid_q;
    ifid_pc_d  = ifid_pc_q;
    ifid_pc4_d = ifid_pc4_q;
    inst_d     = inst_q;
    mis_d      = 1'b0;

    if (redirect_valid) begin
      // Flush: ifid_pc/ifid_pc_plus4 keep their old values, only valid/inst change.
      valid_d = 1'b0;
      inst_d  = NOP_INST;
`ifdef FETCH_MISALIGN_CHK_EN
      if (redirect_target[1:0] != 2'b00) begin
        mis_d = 1'b1;               // drop the redirect, pc holds
      end else begin
        pc_d = redirect_target;
      end
`else
      pc_d = redirect_target & ALIGN_MASK;
`endif
    end else if (!stall) begin
      pc_d       = pc_plus4;
      valid_d    = 1'b1;
      ifid_pc_d  = pc_q;
      ifid_pc4_d = pc_plus4;
      inst_d     = imem_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC & ALIGN_MASK;
      valid_q    <= 1'b0;
      ifid_pc_q  <= '0;
      ifid_pc4_q <= '0;
      inst_q     <= NOP_INST;
      mis_q      <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      valid_q    <= valid_d;
      ifid_pc_q  <= ifid_pc_d;
      ifid_pc4_q <= ifid_pc4_d;
      inst_q     <= inst_d;
      mis_q      <= mis_d;
    end
  end

  assign imem_ra       = pc_q;
  assign ifid_valid    = valid_q;
  assign ifid_pc       = ifid_pc_q;
  assign ifid_pc_plus4 = ifid_pc4_q;
  assign ifid_inst     = inst_q;

`ifdef FETCH_MISALIGN_CHK_EN
  assign fetch_misalign = mis_q;
`else
  // Flag register is constant zero without the checker; keep it referenced.
  logic unused_mis;
  assign unused_mis = mis_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed table-driven bench for fetch_unit plus a PC wrap sequence.
// Latency: checks outputs 1 time unit after each rising edge.
// Backpressure: stall/redirect patterns are part of the vector table.
module tb_fetch_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Main DUT (RESET_PC = 0)
  logic        rst_n, stall, rv;
  logic [8:0]  tgt, ra, ipc, ipc4;
  logic [31:0] rd, inst;
  logic        vld, mis;

  // Wrap DUT (RESET_PC = 0x1FC)
  logic        rst2_n, stall2, rv2;
  logic [8:0]  tgt2, ra2, ipc2, ipc42;
  logic [31:0] rd2, inst2;
  logic        vld2, mis2;

  function automatic logic [31:0] mem(input logic [8:0] a);
    case (a)
      9'h000:  mem = 32'h00007033;
      9'h004:  mem = 32'h00100093;
      9'h008:  mem = 32'h00200113;
      9'h00C:  mem = 32'h00308193;
      9'h054:  mem = 32'h00008413;
      default: mem = 32'hA0000000 | {23'd0, a};
    endcase
  endfunction

  assign rd  = mem(ra);
  assign rd2 = mem(ra2);

  fetch_unit u_dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .redirect_valid(rv), .redirect_target(tgt),
    .imem_ra(ra), .imem_rd(rd), .ifid_valid(vld), .ifid_pc(ipc), .ifid_pc_plus4(ipc4),
`ifdef FETCH_MISALIGN_CHK_EN
    .fetch_misalign(mis),
`endif
    .ifid_inst(inst)
  );

  fetch_unit #(.RESET_PC(9'h1FC)) u_wrap (
    .clk(clk), .rst_n(rst2_n), .stall(stall2), .redirect_valid(rv2), .redirect_target(tgt2),
    .imem_ra(ra2), .imem_rd(rd2), .ifid_valid(vld2), .ifid_pc(ipc2), .ifid_pc_plus4(ipc42),
`ifdef FETCH_MISALIGN_CHK_EN
    .fetch_misalign(mis2),
`endif
    .ifid_inst(inst2)
  );

`ifndef FETCH_MISALIGN_CHK_EN
  assign mis  = 1'b0;
  assign mis2 = 1'b0;
`endif

  typedef struct {
    logic        rst_n;
    logic        stall;
    logic        rv;
    logic [8:0]  tgt;
    logic [8:0]  ra;
    logic        v;
    logic [8:0]  pc;
    logic [8:0]  pc4;
    logic [31:0] inst;
    logic        mis;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs[NV];

  function automatic vec_t mk(input logic r, input logic s, input logic rv_i, input logic [8:0] t,
                              input logic [8:0] era, input logic ev, input logic [8:0] epc,
                              input logic [8:0] epc4, input logic [31:0] ei, input logic em);
    vec_t x;
    x.rst_n = r; x.stall = s; x.rv = rv_i; x.tgt = t;
    x.ra = era; x.v = ev; x.pc = epc; x.pc4 = epc4; x.inst = ei; x.mis = em;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; rv = 1'b0; tgt = '0;
    rst2_n = 1'b0; stall2 = 1'b0; rv2 = 1'b0; tgt2 = '0;

    //                rst  stl rv  tgt     ra      v   pc      pc4     inst          mis
    vecs[0]  = mk(1'b0, 0, 0, 9'h000, 9'h000, 0, 9'h000, 9'h000, 32'h00000013, 0);
    vecs[1]  = mk(1'b0, 0, 0, 9'h000, 9'h000, 0, 9'h000, 9'h000, 32'h00000013, 0);
    vecs[2]  = mk(1'b1, 0, 0, 9'h000, 9'h004, 1, 9'h000, 9'h004, 32'h00007033, 0);
    vecs[3]  = mk(1'b1, 0, 0, 9'h000, 9'h008, 1, 9'h004, 9'h008, 32'h00100093, 0);
    vecs[4]  = mk(1'b1, 0, 0, 9'h000, 9'h00C, 1, 9'h008, 9'h00C, 32'h00200113, 0);
    vecs[5]  = mk(1'b1, 1, 0, 9'h000, 9'h00C, 1, 9'h008, 9'h00C, 32'h00200113, 0);
    vecs[6]  = mk(1'b1, 1, 0, 9'h000, 9'h00C, 1, 9'h008, 9'h00C, 32'h00200113, 0);
    vecs[7]  = mk(1'b1, 1, 0, 9'h000, 9'h00C, 1, 9'h008, 9'h00C, 32'h00200113, 0);
    vecs[8]  = mk(1'b1, 0, 0, 9'h000, 9'h010, 1, 9'h00C, 9'h010, 32'h00308193, 0);
    // redirect together with stall: redirect wins, IF/ID flushed, pc fields hold
    vecs[9]  = mk(1'b1, 1, 1, 9'h054, 9'h054, 0, 9'h00C, 9'h010, 32'h00000013, 0);
    vecs[10] = mk(1'b1, 0, 0, 9'h000, 9'h058, 1, 9'h054, 9'h058, 32'h00008413, 0);
`ifdef FETCH_MISALIGN_CHK_EN
    // misaligned target dropped: pc holds at 0x58, flag for one cycle
    vecs[11] = mk(1'b1, 0, 1, 9'h056, 9'h058, 0, 9'h054, 9'h058, 32'h00000013, 1);
    vecs[12] = mk(1'b1, 0, 0, 9'h000, 9'h05C, 1, 9'h058, 9'h05C, 32'hA0000058, 0);
    vecs[13] = mk(1'b1, 0, 1, 9'h030, 9'h030, 0, 9'h058, 9'h05C, 32'h00000013, 0);
    vecs[14] = mk(1'b1, 0, 1, 9'h030, 9'h030, 0, 9'h058, 9'h05C, 32'h00000013, 0);
`else
    // misaligned target forced down to 0x54
    vecs[11] = mk(1'b1, 0, 1, 9'h056, 9'h054, 0, 9'h054, 9'h058, 32'h00000013, 0);
    vecs[12] = mk(1'b1, 0, 0, 9'h000, 9'h058, 1, 9'h054, 9'h058, 32'h00008413, 0);
    vecs[13] = mk(1'b1, 0, 1, 9'h030, 9'h030, 0, 9'h054, 9'h058, 32'h00000013, 0);
    vecs[14] = mk(1'b1, 0, 1, 9'h030, 9'h030, 0, 9'h054, 9'h058, 32'h00000013, 0);
`endif
    // vecs[14] redirects to the current pc: refetch, still flushed
    vecs[15] = mk(1'b1, 0, 0, 9'h000, 9'h034, 1, 9'h030, 9'h034, 32'hA0000030, 0);
    vecs[16] = mk(1'b1, 1, 0, 9'h000, 9'h034, 1, 9'h030, 9'h034, 32'hA0000030, 0);
    // reset during stall, then reset during redirect
    vecs[17] = mk(1'b0, 1, 0, 9'h000, 9'h000, 0, 9'h000, 9'h000, 32'h00000013, 0);
    vecs[18] = mk(1'b0, 0, 1, 9'h054, 9'h000, 0, 9'h000, 9'h000, 32'h00000013, 0);
    vecs[19] = mk(1'b1, 0, 0, 9'h000, 9'h004, 1, 9'h000, 9'h004, 32'h00007033, 0);

    for (int i = 0; i < NV; i++) begin
      rst_n = vecs[i].rst_n; stall = vecs[i].stall; rv = vecs[i].rv; tgt = vecs[i].tgt;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d imem_ra", i),       {23'd0, ra},   {23'd0, vecs[i].ra});
      chk($sformatf("v%0d ifid_valid", i),    {31'd0, vld},  {31'd0, vecs[i].v});
      chk($sformatf("v%0d ifid_pc", i),       {23'd0, ipc},  {23'd0, vecs[i].pc});
      chk($sformatf("v%0d ifid_pc_plus4", i), {23'd0, ipc4}, {23'd0, vecs[i].pc4});
      chk($sformatf("v%0d ifid_inst", i),     inst,          vecs[i].inst);
`ifdef FETCH_MISALIGN_CHK_EN
      chk($sformatf("v%0d fetch_misalign", i), {31'd0, mis}, {31'd0, vecs[i].mis});
`endif
    end

    // PC wrap with RESET_PC = 0x1FC
    @(posedge clk);
    #1;
    chk("wrap reset imem_ra",   {23'd0, ra2},  32'h1FC);
    chk("wrap reset valid",     {31'd0, vld2}, 32'h0);
    rst2_n = 1'b1;
    @(posedge clk);
    #1;
    chk("wrap1 ifid_pc",        {23'd0, ipc2},  32'h1FC);
    chk("wrap1 ifid_pc_plus4",  {23'd0, ipc42}, 32'h000);
    chk("wrap1 imem_ra",        {23'd0, ra2},   32'h000);
    chk("wrap1 ifid_inst",      inst2,          32'hA00001FC);
    chk("wrap1 valid",          {31'd0, vld2},  32'h1);
    @(posedge clk);
    #1;
    chk("wrap2 ifid_pc",        {23'd0, ipc2},  32'h000);
    chk("wrap2 ifid_pc_plus4",  {23'd0, ipc42}, 32'h004);
    chk("wrap2 ifid_inst",      inst2,          32'h00007033);
    chk("wrap2 misalign idle",  {31'd0, mis2},  32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
